// File: rtl/led_breath_pwm_multi.sv
// Multi-channel LED PWM driver: one shared period counter, per-channel static or breathing duty.
// Config writes are staged per channel and only take effect at the period wrap, so outputs never glitch.
module led_breath_pwm_multi #(
   parameter int CHANNELS     = 4,
   parameter int CLK_HZ       = 12_000_000,
   parameter int PWM_HZ       = 1000,
   parameter int STEP         = 1,
   parameter int STEP_PERIODS = 1,
   localparam int PERIOD      = CLK_HZ / PWM_HZ,
   localparam int CW          = $clog2(PERIOD + 1),
   localparam int CHW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                cfg_we,
   input  logic [CHW-1:0]      cfg_ch,
   input  logic                cfg_mode,
   input  logic [CW-1:0]       cfg_duty,
   output logic [CHANNELS-1:0] led,
   output logic                period_tick,
   output logic                out_clk
);

   localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

   localparam logic [CW-1:0] PERIOD_C  = CW'(PERIOD);
   localparam logic [CW-1:0] PERIOD_M1 = CW'(PERIOD - 1);
   localparam logic [CW-1:0] STEP_C    = CW'(STEP);
   localparam logic [CW:0]   PERIOD_X  = (CW + 1)'(PERIOD);
   localparam logic [CW:0]   STEP_X    = (CW + 1)'(STEP);
   localparam logic [SW-1:0] STEP_M1   = SW'(STEP_PERIODS - 1);

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_t;

   logic [CW-1:0]                cnt;
   logic [SW-1:0]                step_cnt;
   logic                         boundary;
   logic                         step_due;

   logic [CHANNELS-1:0][CW-1:0]  duty, duty_nxt;
   logic [CHANNELS-1:0]          mode, mode_nxt;
   dir_t [CHANNELS-1:0]          dir, dir_nxt;

   logic [CHANNELS-1:0]          pend_valid, pend_valid_nxt;
   logic [CHANNELS-1:0]          pend_mode, pend_mode_nxt;
   logic [CHANNELS-1:0][CW-1:0]  pend_duty, pend_duty_nxt;

   logic [CHANNELS-1:0]          wr_hit;
   logic [CW-1:0]                cfg_duty_clamped;
   logic [CHANNELS-1:0]          led_nxt;

   // Boundary B is the edge on which the counter wraps; stepping only counts B while enabled.
   always_comb begin
      boundary = (cnt == PERIOD_M1);
      step_due = boundary && en && (step_cnt == STEP_M1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         step_cnt    <= '0;
         period_tick <= 1'b0;
         out_clk     <= 1'b0;
      end else begin
         cnt         <= boundary ? '0 : cnt + 1'b1;
         period_tick <= boundary;
         if (boundary) begin
            out_clk <= ~out_clk;
         end
         if (boundary && en) begin
            step_cnt <= (step_cnt == STEP_M1) ? '0 : step_cnt + 1'b1;
         end
      end
   end

   // Channel decode compares against each legal index, so out-of-range cfg_ch simply hits nothing.
   always_comb begin
      cfg_duty_clamped = ({1'b0, cfg_duty} > PERIOD_X) ? PERIOD_C : cfg_duty;
      wr_hit = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (cfg_we && (cfg_ch == CHW'(i))) begin
            wr_hit[i] = 1'b1;
         end
      end
   end

   // A write on the B edge lands after the old pending value has been consumed by that same B.
   always_comb begin
      pend_valid_nxt = pend_valid;
      pend_mode_nxt  = pend_mode;
      pend_duty_nxt  = pend_duty;
      for (int i = 0; i < CHANNELS; i++) begin
         if (wr_hit[i]) begin
            pend_valid_nxt[i] = 1'b1;
            pend_mode_nxt[i]  = cfg_mode;
            pend_duty_nxt[i]  = cfg_duty_clamped;
         end else if (boundary) begin
            pend_valid_nxt[i] = 1'b0;
         end
      end
   end

   // Breathing FSM per channel; arithmetic widened by one bit so duty+STEP cannot overflow.
   always_comb begin
      duty_nxt = duty;
      mode_nxt = mode;
      dir_nxt  = dir;
      for (int i = 0; i < CHANNELS; i++) begin
         if (boundary) begin
            if (pend_valid[i]) begin
               duty_nxt[i] = pend_duty[i];
               mode_nxt[i] = pend_mode[i];
               dir_nxt[i]  = (pend_duty[i] == PERIOD_C) ? DOWN : UP;
            end else if (!mode[i] && step_due) begin
               case (dir[i])
                  UP: begin
                     if (({1'b0, duty[i]} + STEP_X) >= PERIOD_X) begin
                        duty_nxt[i] = PERIOD_C;
                        dir_nxt[i]  = DOWN;
                     end else begin
                        duty_nxt[i] = duty[i] + STEP_C;
                     end
                  end
                  DOWN: begin
                     if ({1'b0, duty[i]} <= STEP_X) begin
                        duty_nxt[i] = '0;
                        dir_nxt[i]  = UP;
                     end else begin
                        duty_nxt[i] = duty[i] - STEP_C;
                     end
                  end
               endcase
            end
         end
      end
   end

   always_comb begin
      led_nxt = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         led_nxt[i] = en && (cnt < duty[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty       <= '0;
         mode       <= '0;
         dir        <= {CHANNELS{UP}};
         pend_valid <= '0;
         pend_mode  <= '0;
         pend_duty  <= '0;
         led        <= '0;
      end else begin
         duty       <= duty_nxt;
         mode       <= mode_nxt;
         dir        <= dir_nxt;
         pend_valid <= pend_valid_nxt;
         pend_mode  <= pend_mode_nxt;
         pend_duty  <= pend_duty_nxt;
         led        <= led_nxt;
      end
   end

endmodule

// File: tb/tb_led_breath_pwm_multi.sv
// Directed bench for led_breath_pwm_multi with PERIOD=10, STEP=2, two channels.
// Each period the high-clock count per channel is compared with hand-computed duties.
module tb_led_breath_pwm_multi;

   localparam int CHANNELS     = 2;
   localparam int CLK_HZ       = 100;
   localparam int PWM_HZ       = 10;
   localparam int STEP         = 2;
   localparam int STEP_PERIODS = 1;
   localparam int CW           = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          cfg_we;
   logic [0:0]    cfg_ch;
   logic          cfg_mode;
   logic [CW-1:0] cfg_duty;
   logic [1:0]    led;
   logic          period_tick;
   logic          out_clk;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   pidx     = 0;
   logic exp_oc   = 1'b0;

   logic          sched_we   [10];
   logic [0:0]    sched_ch   [10];
   logic          sched_mode [10];
   logic [CW-1:0] sched_duty [10];
   logic          sched_drop [10];

   led_breath_pwm_multi #(
      .CHANNELS     (CHANNELS),
      .CLK_HZ       (CLK_HZ),
      .PWM_HZ       (PWM_HZ),
      .STEP         (STEP),
      .STEP_PERIODS (STEP_PERIODS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_mode    (cfg_mode),
      .cfg_duty    (cfg_duty),
      .led         (led),
      .period_tick (period_tick),
      .out_clk     (out_clk)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input int actual, input int expected);
      n_checks++;
      if (actual == expected) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic clear_schedule();
      for (int k = 0; k < 10; k++) begin
         sched_we[k]   = 1'b0;
         sched_ch[k]   = 1'b0;
         sched_mode[k] = 1'b0;
         sched_duty[k] = '0;
         sched_drop[k] = 1'b0;
      end
   endtask

   task automatic schedule_write(input int k, input int ch, input int mode, input int duty);
      sched_we[k]   = 1'b1;
      sched_ch[k]   = 1'(ch);
      sched_mode[k] = 1'(mode);
      sched_duty[k] = CW'(duty);
   endtask

   // Writes driven at negedge k are captured on the edge where the counter equals k.
   task automatic drive_period();
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         cfg_we   = sched_we[k];
         cfg_ch   = sched_ch[k];
         cfg_mode = sched_mode[k];
         cfg_duty = sched_duty[k];
         if (sched_drop[k]) begin
            en = 1'b0;
         end
      end
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic measure_period(output int h0, output int h1, output int early, output int last);
      h0 = 0;
      h1 = 0;
      early = 0;
      last = 0;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         h0 += int'(led[0]);
         h1 += int'(led[1]);
         if (j < 10) begin
            early += int'(period_tick);
         end else begin
            last = int'(period_tick);
         end
      end
   endtask

   // Starts on a tick cycle; covers one full period and ends on the next tick cycle.
   task automatic run_period(input int e0, input int e1);
      int h0, h1, early, last;
      fork
         drive_period();
         measure_period(h0, h1, early, last);
      join
      check_output($sformatf("p%0d led0 highs", pidx), h0, e0);
      check_output($sformatf("p%0d led1 highs", pidx), h1, e1);
      check_output($sformatf("p%0d stray tick", pidx), early, 0);
      check_output($sformatf("p%0d tick at wrap", pidx), last, 1);
      exp_oc = ~exp_oc;
      check_output($sformatf("p%0d out_clk", pidx), int'(out_clk), int'(exp_oc));
      clear_schedule();
      pidx++;
   endtask

   task automatic first_period_after_reset(input string tag);
      int n = 0;
      int h = 0;
      do begin
         @(negedge clk);
         n++;
         h += int'(led[0]) + int'(led[1]);
      end while (!period_tick && n < 30);
      check_output({tag, " clks to first tick"}, n, 10);
      check_output({tag, " led highs first period"}, h, 0);
      exp_oc = ~exp_oc;
      check_output({tag, " out_clk first tick"}, int'(out_clk), int'(exp_oc));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t1[11] = '{2, 4, 6, 8, 10, 8, 6, 4, 2, 0, 2};
      rst = 1'b1;
      en = 1'b1;
      cfg_we = 1'b0;
      cfg_ch = '0;
      cfg_mode = 1'b0;
      cfg_duty = '0;
      clear_schedule();
      repeat (2) @(negedge clk);
      check_output("reset led", int'(led), 0);
      check_output("reset period_tick", int'(period_tick), 0);
      check_output("reset out_clk", int'(out_clk), 0);
      rst = 1'b0;
      first_period_after_reset("start");

      $display("[TB] breathing sweep");
      for (int i = 0; i < 11; i++) begin
         run_period(t1[i], t1[i]);
      end

      $display("[TB] static write to ch1 mid-period");
      schedule_write(4, 1, 1, 3);
      run_period(4, 4);
      run_period(6, 3);
      run_period(8, 3);

      $display("[TB] static duty 0 / 10 / 15 clamped");
      schedule_write(2, 1, 1, 0);
      run_period(10, 3);
      schedule_write(5, 1, 1, 10);
      run_period(8, 0);
      schedule_write(1, 1, 1, 15);
      run_period(6, 10);
      run_period(4, 10);

      $display("[TB] overwrite before wrap and write on wrap edge");
      schedule_write(2, 0, 1, 4);
      schedule_write(6, 0, 1, 6);
      run_period(2, 10);
      run_period(6, 10);
      schedule_write(3, 0, 1, 7);
      schedule_write(9, 0, 1, 5);
      run_period(6, 10);
      run_period(7, 10);

      $display("[TB] enable drop during breathe");
      schedule_write(1, 1, 0, 4);
      run_period(5, 10);
      run_period(5, 4);
      run_period(5, 6);
      sched_drop[2] = 1'b1;
      run_period(2, 2);
      run_period(0, 0);
      run_period(0, 0);
      en = 1'b1;
      run_period(5, 8);
      run_period(5, 10);

      $display("[TB] asynchronous reset with outputs high");
      schedule_write(4, 0, 1, 10);
      run_period(5, 8);
      run_period(10, 6);
      check_output("pre-reset led0", int'(led[0]), 1);
      check_output("pre-reset period_tick", int'(period_tick), 1);
      #2 rst = 1'b1;
      #1;
      check_output("async reset led", int'(led), 0);
      check_output("async reset period_tick", int'(period_tick), 0);
      check_output("async reset out_clk", int'(out_clk), 0);
      @(negedge clk);
      rst = 1'b0;
      exp_oc = 1'b0;
      first_period_after_reset("after reset");
      run_period(2, 2);
      run_period(4, 4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
